memory_arbiter: RTL

Shares the single-port `memory` block between the instruction fetch path and the load/store path of `execute`. Each requester holds a level request until a one-cycle `done` pulse. The arbiter serialises the requests into one memory strobe per transaction, waits out the memory read latency, and returns read data in a registered response. Data accesses have priority over fetches; a starvation limit guarantees forward progress for fetch.

---
 rtl/memory_arbiter_pkg.sv | 27 ++
 rtl/memory_arbiter_if.sv | 60 ++++++
 rtl/memory_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/memory_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_memory_package
//   Types and constants shared by the memory arbiter and the fetch, execute
//   and memory blocks that sit around it.
//   - DEFAULT_ADDRESS_WIDTH / DEFAULT_DATA_WIDTH : default bus widths
//   - arbiter_state_t : IDLE / ACCESS / WAIT / RESPOND
//   - access_kind_t   : FETCH / DATA_READ / DATA_WRITE
// -----------------------------------------------------------------------------
package rv32i_memory_package;

  localparam int DEFAULT_ADDRESS_WIDTH = 32;
  localparam int DEFAULT_DATA_WIDTH    = 32;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESPOND
  } arbiter_state_t;

  typedef enum logic [1:0] {
    FETCH,
    DATA_READ,
    DATA_WRITE
  } access_kind_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// -----------------------------------------------------------------------------
// memory_arbiter_if
//   Bundles the fetch requester, the data (load/store) requester and the
//   single-port memory that the arbiter shares between them.
//   Fetch : fetch_request, fetch_address -> fetch_value, fetch_done
//   Data  : data_request, data_write, data_address, data_write_value
//           -> data_read_value, data_done
//   Memory: memory_read_enable, memory_read_address -> memory_read_value
//           memory_write_enable, memory_write_address, memory_write_value
//   Modports:
//     master : the arbiter side
//     slave  : the requesters plus the memory
// -----------------------------------------------------------------------------
interface memory_arbiter_if
  import rv32i_memory_package::*;
#(
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH
) ();

  logic                     fetch_request;
  logic [ADDRESS_WIDTH-1:0] fetch_address;
  logic [DATA_WIDTH-1:0]    fetch_value;
  logic                     fetch_done;

  logic                     data_request;
  logic                     data_write;
  logic [ADDRESS_WIDTH-1:0] data_address;
  logic [DATA_WIDTH-1:0]    data_write_value;
  logic [DATA_WIDTH-1:0]    data_read_value;
  logic                     data_done;

  logic                     memory_read_enable;
  logic [ADDRESS_WIDTH-1:0] memory_read_address;
  logic [DATA_WIDTH-1:0]    memory_read_value;
  logic                     memory_write_enable;
  logic [ADDRESS_WIDTH-1:0] memory_write_address;
  logic [DATA_WIDTH-1:0]    memory_write_value;

  modport master (
    input  fetch_request, fetch_address,
    output fetch_value, fetch_done,
    input  data_request, data_write, data_address, data_write_value,
    output data_read_value, data_done,
    output memory_read_enable, memory_read_address,
    input  memory_read_value,
    output memory_write_enable, memory_write_address, memory_write_value
  );

  modport slave (
    output fetch_request, fetch_address,
    input  fetch_value, fetch_done,
    output data_request, data_write, data_address, data_write_value,
    input  data_read_value, data_done,
    input  memory_read_enable, memory_read_address,
    output memory_read_value,
    input  memory_write_enable, memory_write_address, memory_write_value
  );

endinterface

// File: rtl/memory_arbiter.sv
// -----------------------------------------------------------------------------
// memory_arbiter
//   Serialises instruction-fetch and load/store requests onto one single-port
//   memory. One strobe per transaction, waits out MEMORY_LATENCY for reads,
//   returns read data in registered outputs and pulses the winner's done.
//   Data wins by default; after STARVATION_LIMIT consecutive data grants with
//   fetch waiting, fetch is granted.
//   Ports:
//     clock : rising-edge clock
//     reset : synchronous, active-high
//     bus   : memory_arbiter_if.master (requesters + memory)
//     busy  : high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module memory_arbiter
  import rv32i_memory_package::*;
#(
  parameter int ADDRESS_WIDTH    = DEFAULT_ADDRESS_WIDTH,
  parameter int DATA_WIDTH       = DEFAULT_DATA_WIDTH,
  parameter int MEMORY_LATENCY   = 1,
  parameter int STARVATION_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  memory_arbiter_if.master  bus,
  output logic              busy
);

  localparam int LATENCY_WIDTH = $clog2(MEMORY_LATENCY) + 1;
  localparam int STARVE_WIDTH  = $clog2(STARVATION_LIMIT) + 1;

  localparam logic [LATENCY_WIDTH-1:0] LATENCY_LOAD = LATENCY_WIDTH'(MEMORY_LATENCY);
  localparam logic [LATENCY_WIDTH-1:0] LATENCY_LAST = LATENCY_WIDTH'(1);
  localparam logic [STARVE_WIDTH-1:0]  STARVE_MAX   = STARVE_WIDTH'(STARVATION_LIMIT);

  arbiter_state_t           state_q, state_d;
  access_kind_t             kind_q;
  access_kind_t             grant_kind;
  logic [ADDRESS_WIDTH-1:0] address_q;
  logic [DATA_WIDTH-1:0]    write_value_q;
  logic [DATA_WIDTH-1:0]    fetch_value_q;
  logic [DATA_WIDTH-1:0]    data_read_value_q;
  logic [LATENCY_WIDTH-1:0] latency_q;
  logic [STARVE_WIDTH-1:0]  starve_q;
  logic                     any_request;
  logic                     fetch_wins;

  // Arbitration: fetch only wins when data is absent or has starved it.
  assign any_request = bus.fetch_request | bus.data_request;
  assign fetch_wins  = bus.fetch_request & (~bus.data_request | (starve_q == STARVE_MAX));
  assign grant_kind  = fetch_wins ? FETCH : (bus.data_write ? DATA_WRITE : DATA_READ);

  // NOTE: combinational logic uses blocking assignments and gives every
  // output a default before the case, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_request) state_d = ACCESS;
      ACCESS:  state_d = (kind_q == DATA_WRITE) ? RESPOND : WAIT;
      WAIT:    if (latency_q == LATENCY_LAST) state_d = RESPOND;
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes and done pulses decode directly from the state and latched kind,
  // so a reset that returns the state to IDLE drops them on the next cycle.
  always_comb begin
    bus.memory_read_enable  = 1'b0;
    bus.memory_write_enable = 1'b0;
    bus.fetch_done          = 1'b0;
    bus.data_done           = 1'b0;
    if (state_q == ACCESS) begin
      bus.memory_read_enable  = (kind_q != DATA_WRITE);
      bus.memory_write_enable = (kind_q == DATA_WRITE);
    end
    if (state_q == RESPOND) begin
      bus.fetch_done = (kind_q == FETCH);
      bus.data_done  = (kind_q != FETCH);
    end
  end

  assign busy                     = (state_q != IDLE);
  assign bus.memory_read_address  = address_q;
  assign bus.memory_write_address = address_q;
  assign bus.memory_write_value   = write_value_q;
  assign bus.fetch_value          = fetch_value_q;
  assign bus.data_read_value      = data_read_value_q;

  // NOTE: sequential state uses non-blocking assignments only; every register
  // here, datapath included, is reset because its reset value is visible on
  // the outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q           <= IDLE;
      kind_q            <= FETCH;
      address_q         <= '0;
      write_value_q     <= '0;
      fetch_value_q     <= '0;
      data_read_value_q <= '0;
      latency_q         <= '0;
      starve_q          <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          // Starvation counts data grants made while fetch is waiting.
          if (!bus.fetch_request) begin
            starve_q <= '0;
          end else if (fetch_wins) begin
            starve_q <= '0;
          end else if (starve_q != STARVE_MAX) begin
            starve_q <= starve_q + STARVE_WIDTH'(1);
          end
          if (any_request) begin
            kind_q        <= grant_kind;
            address_q     <= fetch_wins ? bus.fetch_address : bus.data_address;
            write_value_q <= bus.data_write_value;
          end
        end
        ACCESS: begin
          if (kind_q != DATA_WRITE) latency_q <= LATENCY_LOAD;
        end
        WAIT: begin
          latency_q <= latency_q - LATENCY_WIDTH'(1);
          if (latency_q == LATENCY_LAST) begin
            if (kind_q == FETCH) fetch_value_q     <= bus.memory_read_value;
            else                 data_read_value_q <= bus.memory_read_value;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
